// File: rtl/uart_tx_wb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_wb
// Brief    : Wishbone UART transmitter, 4-byte buffer, 8N1 LSB first, NCO baud.
//            Optional even parity bit when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_wb #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          STOP_BITS  = 1,
  parameter int          IGNORE_CYC = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [31:0] ADDR_CTRL  = BASE_ADDR + 32'h3;
  localparam logic [31:0] ADDR_BAUD  = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_STAT  = BASE_ADDR + 32'h5;
  localparam logic [31:0] ADDR_TXBUF = BASE_ADDR + 32'h7;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd6;
`endif

  logic [2:0]  state_q, state_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] baud_q, baud_d;
  logic [31:0] txbuf_q, txbuf_d;
  logic [3:0]  lane_q, lane_d;
  logic [31:0] nco_q, nco_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_PARITY_EN
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
`endif

  logic        acc;
  logic        wr;
  logic [32:0] nco_sum;
  logic        tick;
  logic        last_stop;
  logic        start_wr;
  logic        par_rd;
  logic [1:0]  lane_idx;
  logic [7:0]  lane_byte;
  logic [31:0] rd_data;
  logic [2:0]  step;

  assign acc       = stb_i & (cyc_i | (IGNORE_CYC != 0));
  assign wr        = acc & we_i;
  assign nco_sum   = {1'b0, nco_q} + {1'b0, baud_q};
  assign tick      = nco_sum[32];
  assign last_stop = (STOP_BITS < 2) | stop_cnt_q;
  assign start_wr  = wr & (addr_i == ADDR_CTRL) & dat_i[7];

`ifdef UART_TX_PARITY_EN
  assign par_rd = par_en_q;
`else
  assign par_rd = 1'b0;
`endif

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) r[n*8 +: 8] = new_v[n*8 +: 8];
    end
    return r;
  endfunction

  // Lowest pending lane wins.
  always_comb begin
    lane_idx = 2'd3;
    casez (lane_q)
      4'b???1: lane_idx = 2'd0;
      4'b??10: lane_idx = 2'd1;
      4'b?100: lane_idx = 2'd2;
      default: lane_idx = 2'd3;
    endcase
    lane_byte = txbuf_q[{lane_idx, 3'b000} +: 8];
  end

  always_comb begin
    rd_data = 32'h0;
    case (addr_i)
      ADDR_CTRL:  rd_data = {24'h0, busy_q, 6'h0, par_rd};
      ADDR_BAUD:  rd_data = baud_q;
      ADDR_STAT:  rd_data = {26'h0, done_q, busy_q, lane_q};
      ADDR_TXBUF: rd_data = txbuf_q;
      default:    rd_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ack_d      = acc;
    dat_d      = acc ? rd_data : dat_q;
    baud_d     = baud_q;
    txbuf_d    = txbuf_q;
    lane_d     = lane_q;
    nco_d      = nco_sum[31:0];
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    step       = state_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    if (wr && addr_i == ADDR_CTRL) par_en_d = dat_i[0];
`endif

    if (wr && addr_i == ADDR_BAUD) baud_d = merge_lanes(baud_q, dat_i, sel_i);
    if (wr && addr_i == ADDR_STAT) done_d = 1'b0;
    if (wr && addr_i == ADDR_TXBUF && !busy_q) begin
      txbuf_d = merge_lanes(txbuf_q, dat_i, sel_i);
      lane_d  = lane_q | sel_i;
    end

    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          busy_d = 1'b1;
          nco_d  = 32'h0;
          step   = S_SELECT;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
`else
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (last_stop) step = S_SELECT;
          else stop_cnt_d = 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Lane selection resolves in the cycle it is entered so frames abut.
    if (step == S_SELECT) begin
      if (|lane_q) begin
        shift_d          = lane_byte;
        lane_d[lane_idx] = 1'b0;
        tx_d             = 1'b0;
        state_d          = S_START;
`ifdef UART_TX_PARITY_EN
        par_bit_d        = ^lane_byte;
`endif
      end else begin
        tx_d    = 1'b1;
        state_d = S_FINISH;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      baud_q     <= 32'h0;
      txbuf_q    <= 32'h0;
      lane_q     <= 4'h0;
      nco_q      <= 32'h0;
      shift_q    <= 8'h0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      baud_q     <= baud_d;
      txbuf_q    <= txbuf_d;
      lane_q     <= lane_d;
      nco_q      <= nco_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  assign dat_o  = dat_q;
  assign ack_o  = ack_q;
  assign err_o  = 1'b0;
  assign rty_o  = 1'b0;
  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_wb
// Brief    : Scoreboard bench for uart_tx_wb: bus reads and serial frames are
//            queued as expectations and checked by independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_wb;

  localparam logic [31:0] A_CTRL  = 32'h3;
  localparam logic [31:0] A_BAUD  = 32'h4;
  localparam logic [31:0] A_STAT  = 32'h5;
  localparam logic [31:0] A_TXBUF = 32'h7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [3:0]  sel = 4'h0;
  wire  [31:0] dat_o;
  wire         ack_o, err_o, rty_o, tx_o, busy_o, done_o;

  int checks = 0;
  int failures = 0;
  int bc = 2;
  int done_rises = 0;
  logic done_prev = 1'b0;
  logic rx_kill = 1'b0;
  logic ack_exp, rd_pend;

  logic [31:0] exp_rd_q[$];
  logic [9:0]  exp_tx_q[$];   // {has_parity, parity, byte}

  uart_tx_wb dut (
    .clk_i (clk), .rst_i (rst), .addr_i (addr), .dat_i (wdat), .dat_o (dat_o),
    .we_i (we), .sel_i (sel), .cyc_i (cyc), .stb_i (stb), .ack_o (ack_o),
    .err_o (err_o), .rty_o (rty_o), .tx_o (tx_o), .busy_o (busy_o), .done_o (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_exp <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      ack_exp <= stb;
      rd_pend <= stb & ~we;
    end
  end

  // Bus monitor: ack timing every cycle, read data popped against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ack", {31'h0, ack_o}, {31'h0, ack_exp});
      if (ack_o && rd_pend) begin
        if (exp_rd_q.size() == 0) chk("read_unexpected", dat_o, 32'hxxxx_xxxx);
        else chk("read", dat_o, exp_rd_q.pop_front());
      end
    end
    if (done_o === 1'b1 && done_prev === 1'b0) done_rises++;
    done_prev = done_o;
  end

  // Serial monitor: samples the last cycle of every bit period.
  initial begin
    logic [7:0] b;
    logic       p, stp, has_p;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx_o === 1'b0) begin
        has_p = (exp_tx_q.size() > 0) ? exp_tx_q[0][9] : 1'b0;
        p = 1'b0;
        repeat (bc - 1) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (bc) @(negedge clk);
          b[k] = tx_o;
        end
        if (has_p) begin
          repeat (bc) @(negedge clk);
          p = tx_o;
        end
        repeat (bc) @(negedge clk);
        stp = tx_o;
        if (!rx_kill) begin
          if (exp_tx_q.size() == 0) begin
            chk("rx_unexpected_frame", {24'h0, b}, 32'hxxxx_xxxx);
          end else begin
            e = exp_tx_q.pop_front();
            chk("rx_byte", {24'h0, b}, {24'h0, e[7:0]});
            if (has_p) chk("rx_parity", {31'h0, p}, {31'h0, e[8]});
            chk("rx_stop", {31'h0, stp}, 32'h1);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic c);
    we = w; addr = a; wdat = d; sel = s; cyc = c; stb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_cyc(1'b1, a, d, s, 1'b1);
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    exp_rd_q.push_back(exp);
    bus_cyc(1'b0, a, 32'h0, 4'h0, 1'b1);
    bus_idle();
  endtask

  task automatic wait_not_busy(input int max);
    int i;
    i = 0;
    while (busy_o !== 1'b0 && i < max) begin
      tick(1);
      i++;
    end
    chk("busy_timeout", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    logic [9:0]  lv;
    logic [19:0] wave, wexp;
    int          rises0;

    // Power-on reset
    tick(3);
    chk("rst_tx", {31'h0, tx_o}, 32'h1);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    rst = 1'b0;
    tick(2);

    // BAUD byte lanes, then reset while idle
    wr(A_BAUD, 32'h1234_5678, 4'hF);
    rd(A_BAUD, 32'h1234_5678);
    wr(A_BAUD, 32'hAABB_CCDD, 4'b0101);
    rd(A_BAUD, 32'h12BB_56DD);
    rd(32'h6, 32'h0);
    wr(32'h6, 32'hFFFF_FFFF, 4'hF);
    rd(32'h0, 32'h0);
    tick(2);
    rst = 1'b1;
    #1;
    chk("idle_rst_tx", {31'h0, tx_o}, 32'h1);
    chk("idle_rst_ack", {31'h0, ack_o}, 32'h0);
    chk("idle_rst_dat", dat_o, 32'h0);
    tick(2);
    rst = 1'b0;
    rd(A_BAUD, 32'h0);

    // Single byte 0xA5 at two cycles per bit
    wr(A_BAUD, 32'h8000_0000, 4'hF);
    exp_rd_q.push_back(32'h8000_0000);
    bus_cyc(1'b0, A_BAUD, 32'h0, 4'h0, 1'b0);   // cyc low still accepted
    bus_idle();
    wr(A_TXBUF, 32'h0000_00A5, 4'b0001);
    rd(A_STAT, 32'h0000_0001);
    exp_tx_q.push_back({2'b00, 8'hA5});
    wr(A_CTRL, 32'h80, 4'h0);
    lv = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 20; i++) begin
      wave[i] = tx_o;
      wexp[i] = lv[i / 2];
      tick(1);
    end
    chk("a5_waveform", {12'h0, wave}, {12'h0, wexp});
    wait_not_busy(10);
    chk("a5_tx_idle", {31'h0, tx_o}, 32'h1);
    rd(A_STAT, 32'h0000_0020);
    chk("a5_done", {31'h0, done_o}, 32'h1);
    wr(A_STAT, 32'h0, 4'h0);
    rd(A_STAT, 32'h0);
    chk("clr_done", {31'h0, done_o}, 32'h0);

    // Four lanes back-to-back
    wr(A_TXBUF, 32'h4433_2211, 4'hF);
    rd(A_STAT, 32'h0000_000F);
    exp_tx_q.push_back({2'b00, 8'h11});
    exp_tx_q.push_back({2'b00, 8'h22});
    exp_tx_q.push_back({2'b00, 8'h33});
    exp_tx_q.push_back({2'b00, 8'h44});
    rises0 = done_rises;
    wr(A_CTRL, 32'h80, 4'h0);
    wait_not_busy(120);
    tick(2);
    chk("four_done_once", done_rises - rises0, 32'd1);
    rd(A_STAT, 32'h0000_0020);
    rd(A_TXBUF, 32'h4433_2211);
    wr(A_STAT, 32'h0, 4'h0);

    // Writes while busy are ignored
    wr(A_TXBUF, 32'h0000_005A, 4'b0001);
    exp_tx_q.push_back({2'b00, 8'h5A});
    wr(A_CTRL, 32'h80, 4'h0);
    wr(A_TXBUF, 32'h0000_00FF, 4'b0001);
    wr(A_CTRL, 32'h80, 4'h0);
    rd(A_STAT, 32'h0000_0010);
    rd(A_TXBUF, 32'h4433_225A);
    rd(A_CTRL, 32'h0000_0080);
    wait_not_busy(40);
    tick(20);
    rd(A_STAT, 32'h0000_0020);
    wr(A_STAT, 32'h0, 4'h0);
    rd(A_STAT, 32'h0);
    chk("busy_clr_done", {31'h0, done_o}, 32'h0);

    // Empty start with STAT clear landing in the FINISH cycle
    bus_cyc(1'b1, A_CTRL, 32'h80, 4'h0, 1'b1);
    bus_cyc(1'b1, A_STAT, 32'h0, 4'h0, 1'b1);
    bus_idle();
    chk("set_wins_done", {31'h0, done_o}, 32'h1);
    chk("empty_tx", {31'h0, tx_o}, 32'h1);
    rd(A_STAT, 32'h0000_0020);
    wr(A_STAT, 32'h0, 4'h0);
    wr(A_CTRL, 32'h80, 4'h0);
    tick(1);
    chk("empty_done_2cyc", {31'h0, done_o}, 32'h1);
    chk("empty_tx2", {31'h0, tx_o}, 32'h1);

    // Parity enable bit
`ifdef UART_TX_PARITY_EN
    wr(A_STAT, 32'h0, 4'h0);
    wr(A_TXBUF, 32'h0000_0007, 4'b0001);
    exp_tx_q.push_back({2'b11, 8'h07});
    wr(A_CTRL, 32'h81, 4'h0);
    wait_not_busy(40);
    rd(A_CTRL, 32'h0000_0001);
    wr(A_CTRL, 32'h00, 4'h0);
    rd(A_CTRL, 32'h0);
`else
    wr(A_CTRL, 32'h01, 4'h0);
    rd(A_CTRL, 32'h0);
`endif

    // Reset in the middle of the data bits of a 0x00 byte
    wr(A_TXBUF, 32'h0, 4'b0001);
    rx_kill = 1'b1;
    wr(A_CTRL, 32'h80, 4'h0);
    tick(4);
    chk("pre_rst_tx_low", {31'h0, tx_o}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", {31'h0, tx_o}, 32'h1);
    chk("async_rst_busy", {31'h0, busy_o}, 32'h0);
    tick(2);
    rst = 1'b0;
    rd(A_BAUD, 32'h0);
    rd(A_STAT, 32'h0);
    tick(30);
    rx_kill = 1'b0;

    tick(5);
    chk("err_rty", {30'h0, err_o, rty_o}, 32'h0);
    chk("rd_queue_empty", exp_rd_q.size(), 32'd0);
    chk("tx_queue_empty", exp_tx_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
